// File: rtl/video_timing_pkg.sv
// Mode-timing constants and coordinate-width helper shared by the raster timing generator.
package video_timing_pkg;

  // 640x480 @ 60 Hz, negative syncs
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam int VGA640_SYNC_POL = 0;

  // 800x600 @ 60 Hz, positive syncs
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;
  localparam int SVGA800_SYNC_POL = 1;

  // Bits needed to hold 0..max(h_total,v_total)-1
  function automatic int coord_width(input int h_total, input int v_total);
    int m;
    m = (h_total > v_total) ? h_total : v_total;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pix_ce_div.sv
// Integer clock-enable divider: ce is high one system clock in every CLK_DIV.
module pix_ce_div #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic ce
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_reg;
  logic [DW-1:0] div_next;

  always_comb begin
    div_next = div_reg;
    if (en) begin
      div_next = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_next;
    end
  end

  // With CLK_DIV=1 the register never leaves 0, so ce is constantly high
  assign ce = (div_reg == DIV_LAST);

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator (coordinates, syncs, DE, line/frame strobes).
// Optional frame counter output enabled by defining VTG_FRAME_COUNT_EN.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE   = VGA640_H_ACTIVE,
  parameter int H_FP       = VGA640_H_FP,
  parameter int H_SYNC     = VGA640_H_SYNC,
  parameter int H_BP       = VGA640_H_BP,
  parameter int V_ACTIVE   = VGA640_V_ACTIVE,
  parameter int V_FP       = VGA640_V_FP,
  parameter int V_SYNC     = VGA640_V_SYNC,
  parameter int V_BP       = VGA640_V_BP,
  parameter int H_SYNC_POL = VGA640_SYNC_POL,
  parameter int V_SYNC_POL = VGA640_SYNC_POL,
  parameter int CLK_DIV    = 1,
  parameter int CW         = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          pix_ce,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          h_sync,
  output logic          v_sync,
  output logic          de,
  output logic          blanking,
  output logic          line_start,
  output logic          frame_start
`ifdef VTG_FRAME_COUNT_EN
  , output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic HS_ON = (H_SYNC_POL != 0);
  localparam logic VS_ON = (V_SYNC_POL != 0);

  if (CLK_DIV < 1) begin : g_chk_div
    $error("video_timing_gen: CLK_DIV must be >= 1");
  end
  if (CW < coord_width(H_TOTAL, V_TOTAL)) begin : g_chk_cw
    $error("video_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_chk_porch
    $error("video_timing_gen: porch and sync widths must be non-zero");
  end

  logic          ce;
  logic          advance;
  logic          x_wrap;
  logic          y_wrap;
  logic [CW-1:0] x_reg, x_next;
  logic [CW-1:0] y_reg, y_next;
  logic          h_sync_reg, v_sync_reg, de_reg, blanking_reg;
  logic          line_start_reg, frame_start_reg;

  pix_ce_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .ce  (ce)
  );

  assign advance = ce & en;
  assign x_wrap  = (x_reg == CW'(H_TOTAL - 1));
  assign y_wrap  = (y_reg == CW'(V_TOTAL - 1));

  always_comb begin
    x_next = x_reg;
    y_next = y_reg;
    if (advance) begin
      if (x_wrap) begin
        x_next = '0;
        y_next = y_wrap ? '0 : y_reg + 1'b1;
      end else begin
        x_next = x_reg + 1'b1;
      end
    end
  end

  // Level outputs decode next-state coordinates so they stay aligned with x/y
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg           <= '0;
      y_reg           <= '0;
      h_sync_reg      <= ~HS_ON;
      v_sync_reg      <= ~VS_ON;
      de_reg          <= 1'b1;
      blanking_reg    <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      x_reg           <= x_next;
      y_reg           <= y_next;
      h_sync_reg      <= ((x_next >= CW'(H_ACTIVE + H_FP)) &&
                          (x_next <  CW'(H_ACTIVE + H_FP + H_SYNC))) ? HS_ON : ~HS_ON;
      v_sync_reg      <= ((y_next >= CW'(V_ACTIVE + V_FP)) &&
                          (y_next <  CW'(V_ACTIVE + V_FP + V_SYNC))) ? VS_ON : ~VS_ON;
      de_reg          <= (x_next < CW'(H_ACTIVE)) && (y_next < CW'(V_ACTIVE));
      blanking_reg    <= ~((x_next < CW'(H_ACTIVE)) && (y_next < CW'(V_ACTIVE)));
      line_start_reg  <= advance & x_wrap;
      frame_start_reg <= advance & x_wrap & y_wrap;
    end
  end

`ifdef VTG_FRAME_COUNT_EN
  logic [15:0] frame_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_reg <= '0;
    end else if (advance && x_wrap && y_wrap) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_reg;
`endif

  assign pix_ce      = ce;
  assign x           = x_reg;
  assign y           = y_reg;
  assign h_sync      = h_sync_reg;
  assign v_sync      = v_sync_reg;
  assign de          = de_reg;
  assign blanking    = blanking_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

endmodule
